// File: rtl/tdm_mux8_rr.sv
// 8:1 round-robin collector: merges eight valid/ready channels onto one registered output.
// Each beat carries its source channel on out_sel, which drives the far-end 1:8 demux.
module tdm_mux8_rr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       last_grant;
  logic [2:0]       grant;
  logic             found;
  logic             any_req;
  logic             load_en;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (state == FULL);
  assign any_req   = |in_valid;
  assign load_en   = (state == EMPTY) || out_ready;

  // Scan starts just past last_grant; the 3-bit add wraps 7->0 on its own.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!found && in_valid[last_grant + 3'(i)]) begin
        grant = last_grant + 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) == grant) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gate keeps in_ready low while reset is held, before any clock edge.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && any_req) in_ready = 8'(1) << grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= 3'd7;
    end else if (load_en) begin
      if (any_req) begin
        state      <= FULL;
        out_data   <= grant_data;
        out_sel    <= grant;
        last_grant <= grant;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux8_rr.sv
// Randomized and directed bench for tdm_mux8_rr against a beat-level round-robin
// model, with a far-end 1:8 demux scoreboard fed from out_data/out_sel.
module tb_tdm_mux8_rr;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  tdm_mux8_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: one output slot plus a round-robin pointer.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic [W-1:0] sb [8][$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [7:0] v, input int ptr);
    for (int k = 1; k <= 8; k++) begin
      if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 7;
    for (int c = 0; c < 8; c++) sb[c].delete();
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int           g;
    logic [7:0]   exp_rdy;
    logic [W-1:0] d;
    int           c;
    #1;
    g = model_grant(in_valid, m_ptr);
    exp_rdy = ((!m_valid || out_ready) && g >= 0) ? (8'd1 << g) : 8'h00;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid && out_ready) begin
      c = int'(out_sel);
      check_eq("demux_has_beat", 32'(sb[c].size() > 0), 32'd1);
      if (sb[c].size() > 0) begin
        d = sb[c].pop_front();
        check_eq("demux_data", 32'(out_data), 32'(d));
      end
    end
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        d = in_data[g*W +: W];
        sb[g].push_back(d);
        m_valid = 1'b1;
        m_data  = d;
        m_sel   = g;
        m_ptr   = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_sel", 32'(out_sel), 32'(m_sel));
    check_eq("out_data", 32'(out_data), 32'(m_data));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset held with every channel requesting.
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h00);
    @(negedge clk);
    @(negedge clk);

    // Single request on ch5 after release.
    rst_n     = 1'b1;
    in_valid  = 8'h20;
    in_data   = '0;
    in_data[5*W +: W] = W'(1);
    out_ready = 1'b1;
    tick();
    check_eq("t2_sel", 32'(out_sel), 32'd5);
    check_eq("t2_data", 32'(out_data), 32'd1);

    // All channels from a fresh pointer: 0..7 then 0.
    in_valid = 8'h00;
    do_reset();
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      in_data = 32'($urandom);
      tick();
      check_eq("t3_seq", 32'(out_sel), 32'(i % 8));
    end

    // Advance to sel 3, stall for 4 cycles, then resume with grant 4.
    for (int i = 0; i < 3; i++) tick();
    check_eq("t4_sel3", 32'(out_sel), 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'($urandom);
      tick();
      check_eq("t4_hold_sel", 32'(out_sel), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    check_eq("t4_resume", 32'(out_sel), 32'd4);

    // Only ch2 and ch6 request: 6, 2, 6.
    in_valid = 8'h44;
    tick();
    check_eq("t5_g0", 32'(out_sel), 32'd6);
    tick();
    check_eq("t5_g1", 32'(out_sel), 32'd2);
    tick();
    check_eq("t5_g2", 32'(out_sel), 32'd6);

    // Load ch4, then reset mid-cycle with no clock edge.
    in_valid = 8'h10;
    tick();
    check_eq("t6_sel4", 32'(out_sel), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(out_valid), 32'd0);
    check_eq("t6_async_ready", 32'(in_ready), 32'h00);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 8'h11;
    tick();
    check_eq("t6_first", 32'(out_sel), 32'd0);

    // Random traffic with sparse requests and backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 8'($urandom) & 8'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    // Drain the output slot so the last beats reach the demux scoreboard.
    in_valid  = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int c = 0; c < 8; c++) check_eq("demux_drained", 32'(sb[c].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
